// File: rtl/topk_dump_streamer.sv
// Keeps the K largest unsigned samples in a sorted array and streams them out
// largest-first over valid/ready when a dump is requested; readout clears the array.
`timescale 1ns/1ps
module topk_dump_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  localparam int CW        = $clog2(K+1),
  localparam int IW        = $clog2(K)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  dump,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [CW-1:0]         count,
  output logic                  busy
);

  typedef enum logic {ST_ACCEPT, ST_DUMP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] top_q [K];
  logic [DATA_WIDTH-1:0] top_d [K];
  logic [DATA_WIDTH-1:0] ins_arr [K];
  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         pos;
  logic [CW-1:0]         count_ins;
  logic                  ins;

  // pos = number of filled entries >= din, i.e. the first slot din strictly beats.
  always_comb begin
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if ((CW'(i) < count_q) && (top_q[i] >= din)) pos = pos + CW'(1);
    end
    ins = din_valid && (pos < CW'(K));
    ins_arr = top_q;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) == pos) ins_arr[i] = din;
    end
    for (int i = 1; i < K; i++) begin
      if (CW'(i) > pos) ins_arr[i] = top_q[i-1];
    end
    count_ins = count_q;
    if (ins && (count_q != CW'(K))) count_ins = count_q + CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    count_d    = count_q;
    idx_d      = idx_q;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        din_ready = 1'b1;
        if (ins) begin
          top_d   = ins_arr;
          count_d = count_ins;
        end
        // the same-cycle insert is counted, so a lone new sample can be dumped
        if (dump && (count_ins != '0)) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        dout       = top_q[idx_q];
        dout_last  = (CW'(idx_q) == (count_q - CW'(1)));
        if (dout_ready) begin
          if (dout_last) begin
            for (int i = 0; i < K; i++) top_d[i] = '0;
            count_d = '0;
            idx_d   = '0;
            state_d = ST_ACCEPT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCEPT;
      count_q <= '0;
      idx_q   <= '0;
      for (int i = 0; i < K; i++) top_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      top_q   <= top_d;
    end
  end

  assign count = count_q;

endmodule
